l1_avgpool_stage: RTL

- Downstream of the dilated-conv/maxpool engine: consumes its 32x32 layer-1 feature map from the shared result memory.
- Performs 2x2, stride-2 average pooling with round-half-up.
- Writes the resulting 16x16 layer-2 map to a separate bank.
- Started by a one-cycle start pulse once the upstream engine drops busy; signals completion with a done pulse.

---
 rtl/l1_avgpool_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/l1_avgpool_stage.sv
// l1_avgpool_stage
//   Reads the IN_W x IN_W layer-1 feature map from the shared result memory,
//   performs 2x2 stride-2 average pooling with round-half-up, and writes the
//   (IN_W/2) x (IN_W/2) layer-2 map to its own bank.
//
//   Ports:
//     clk       - sole clock, rising edge
//     reset     - synchronous, active-high
//     start     - begins one pooling pass; sampled only while idle
//     busy      - high from the first read cycle through the done cycle
//     done      - one-cycle pulse after the last layer-2 write
//     crd       - layer-1 read strobe
//     caddr_rd  - layer-1 read address, row*IN_W + col
//     cdata_rd  - layer-1 read data, valid the cycle after crd/caddr_rd
//     cwr       - layer-2 write strobe
//     caddr_wr  - layer-2 write address, r*(IN_W/2) + c
//     cdata_wr  - layer-2 write data
//
//   Build option: define AVGPOOL_CLIP_EN to saturate written values at CLIP_MAX.

module l1_avgpool_stage #(
  parameter int              IN_W     = 32,
  parameter int              DATA_W   = 13,
  parameter logic [DATA_W-1:0] CLIP_MAX = 13'h0FF0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     crd,
  output logic [2*$clog2(IN_W)-1:0] caddr_rd,
  input  logic [DATA_W-1:0]        cdata_rd,
  output logic                     cwr,
  output logic [2*$clog2(IN_W)-3:0] caddr_wr,
  output logic [DATA_W-1:0]        cdata_wr
);

  localparam int LW    = $clog2(IN_W);
  localparam int CW    = LW - 1;        // output row/col counter width
  localparam int RA_W  = 2 * LW;
  localparam int WA_W  = 2 * LW - 2;
  localparam int ACC_W = DATA_W + 2;    // sum of four pixels never overflows

`ifdef AVGPOOL_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        n;
  logic [CW-1:0]     r, c;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  rounded;
  logic [DATA_W-1:0] avg, wr_val;
  logic              last_out;
  logic [RA_W-1:0]   rd_addr_now, rd_addr_q;
  logic [WA_W-1:0]   wr_addr_now, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign last_out = (r == {CW{1'b1}}) && (c == {CW{1'b1}});

  // Pixel (2r + n[1], 2c + n[0]) of the 2x2 block; row-major concat gives
  // row*IN_W + col directly.
  assign rd_addr_now = {r, n[1], c, n[0]};
  assign wr_addr_now = {r, c};

  assign rounded = acc + ACC_W'(2);
  assign avg     = DATA_W'(rounded >> 2);
  assign wr_val  = (CLIP_ON && (avg > CLIP_MAX)) ? CLIP_MAX : avg;

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  if (n == 3'd4) state_nx = S_WRITE;
      S_WRITE: state_nx = last_out ? S_DONE : S_READ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // outputs; addresses and write data hold their last driven value
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    crd      = (state == S_READ) && (n != 3'd4);
    cwr      = (state == S_WRITE);
    caddr_rd = crd ? rd_addr_now : rd_addr_q;
    caddr_wr = cwr ? wr_addr_now : wr_addr_q;
    cdata_wr = cwr ? wr_val      : wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      n         <= '0;
      r         <= '0;
      c         <= '0;
      acc       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state     <= state_nx;
      rd_addr_q <= caddr_rd;
      wr_addr_q <= caddr_wr;
      wr_data_q <= cdata_wr;
      case (state)
        S_IDLE: begin
          n   <= '0;
          acc <= '0;
        end
        S_READ: begin
          if (n != 3'd4) n <= n + 3'd1;
          // data for read n-1 arrives while n is presented
          if (n != 3'd0) acc <= acc + ACC_W'(cdata_rd);
        end
        S_WRITE: begin
          n   <= '0;
          acc <= '0;
          c   <= c + 1'b1;                       // wraps at IN_W/2
          if (c == {CW{1'b1}}) r <= r + 1'b1;    // wraps to 0 after last row
        end
        default: ;
      endcase
    end
  end

endmodule
